alu_ctrl_decode: RTL and testbench
==================================

# alu_ctrl_decode

Registered decode stage that produces the operation-select side of the ALU interface. It takes a fetched RV32I instruction word over a valid/ready handshake and emits a one-entry pipeline register holding `alu_op`, operand selects, the immediate and branch/jump flags. It sits between instruction fetch and execute, and is the initiator of every ALU operation. The ALU's `f` output is consumed downstream under `is_branch`.

## Interface
- `NOP_INST`, default 32'h0000_0013 (addi x0,x0,0): instruction whose decode is loaded on reset and flush.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inst`  in  32  instruction word; sampled when `in_valid && in_ready`.
- `in_valid`  in  1  `inst` is valid.
- `in_ready`  out  1  stage can accept; equals `!out_valid || out_ready` (combinational).
- `flush`  in  1  discard the held entry and any concurrent input.
- `out_valid`  out  1  registered outputs hold a decoded instruction.
- `out_ready`  in  1  execute consumes the entry this cycle.
- `alu_op`  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 eq, 9 ne, A lt, B ge, C ltu, D geu.
- `a_sel`  out  2  ALU operand a: 0 rs1, 1 pc, 2 zero.
- `b_sel`  out  1  ALU operand b: 0 rs2, 1 imm.
- `imm`  out  32  sign-extended immediate (I/S/B/U/J format per opcode).
- `is_branch`  out  1  conditional branch; the ALU flag selects taken.
- `is_jump`  out  1  jal/jalr.
- `illegal`  out  1  undecodable instruction (see Configuration).

## Operation
- Decode is combinational from `inst`. Results are captured into the output register on accept.
- R-type (0110011): funct3 000 gives add, or sub when funct7=0100000. 001 sll; 010 lt; 011 ltu; 100 xor; 101 srl, or sra when funct7=0100000; 110 or; 111 and. Selects are a=rs1, b=rs2.
- I-ALU (0010011): the same funct3 map, with no sub. srai is selected by funct7. For slli/srli/srai, funct7 must be 0000000 or 0100000 (srai only), otherwise the instruction is illegal. Selects are a=rs1, b=imm.
- Load (0000011) and store (0100011): add, a=rs1, b=imm (I-type and S-type imm respectively).
- Branch (1100011): funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu. Selects are a=rs1, b=rs2. `imm` carries the B-offset and `is_branch`=1. funct3 010 and 011 are illegal.
- lui (0110111): add, a=zero, b=imm (U-type).
- auipc (0010111): add, a=pc, b=imm.
- jal (1101111): add, a=pc, b=imm (J-type), `is_jump`=1.
- jalr (1100111, funct3 000): add, a=rs1, b=imm, `is_jump`=1.
- Any other opcode or funct combination is illegal.
- Register update priority:
  - `rst`: load the decode of `NOP_INST` and clear `out_valid`.
  - else `flush`: load the NOP decode and clear `out_valid`. Concurrent input is dropped.
  - else accept: load the decoded fields and set `out_valid`.
  - else if `out_ready`: clear `out_valid`, fields held.
  - else hold.
- Payload fields never change while `out_valid && !out_ready` (stall stability).

## Timing
- Latency is 1 cycle: the edge that accepts `inst` makes the decode visible with `out_valid`=1.
- Throughput is 1 instruction per cycle when `out_ready` is held high. Back-to-back accept with simultaneous consume is allowed.
- Reset values for default `NOP_INST`:
  - `out_valid`=0, `alu_op`=0, `a_sel`=0, `b_sel`=1, `imm`=0.
  - `is_branch`=0, `is_jump`=0, `illegal`=0.
  - `in_ready`=1.
- Reset asserted mid-stall takes effect immediately, asynchronously, and the held entry is lost.
- `flush` together with `in_valid && in_ready` results in `out_valid`=0 the next cycle. The input counts as consumed by the handshake but is discarded.
- `in_ready` depends combinationally on `out_ready`. There is no other combinational input-to-output path.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - Undecodable instructions set `illegal`=1.
  - They also force `alu_op`=0, `a_sel`=0, `b_sel`=0, `is_branch`=0 and `is_jump`=0.
- Not defined:
  - `illegal` is tied to 0.
  - Undecodable instructions decode as add with a=rs1, b=imm and no branch/jump, i.e. they are treated as NOPs.

## Test plan
- 0x402081B3 (sub x3,x1,x2), with `out_ready`=1 → next cycle: `out_valid`=1, `alu_op`=1, `a_sel`=0, `b_sel`=0.
- 0xFFF00093 (addi x1,x0,-1) followed by 0x4032D293 (srai x5,x5,3), back to back:
  - first: `alu_op`=0, `imm`=0xFFFFFFFF, `b_sel`=1;
  - second: `alu_op`=7, `imm[4:0]`=3.
- 0x0020E463 (bltu x1,x2,8) → `alu_op`=0xC, `is_branch`=1, `imm`=8, `b_sel`=0.
- Stall:
  - stimulus: hold `out_ready`=0 for 3 cycles with `in_valid`=1;
  - required: `in_ready`=0 and all outputs stable;
  - on release, exactly one consume, then the next instruction is accepted.
- Flush and reset:
  - `flush`=1 concurrent with accepting 0x00000013 → `out_valid`=0 next cycle;
  - `rst` pulse between clock edges → `out_valid` drops without waiting for an edge.
- Illegal instruction 0xFFFFFFFF:
  - with `DECODE_ILLEGAL_TRAP_EN` → `illegal`=1, `alu_op`=0;
  - without it → `illegal`=0.

Source files
------------

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage feeding the ALU: valid/ready input, one-entry registered output.
// Define DECODE_ILLEGAL_TRAP_EN to flag undecodable instructions instead of decoding them as NOPs.
module alu_ctrl_decode #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [31:0] imm,
    output logic        is_branch,
    output logic        is_jump,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SLL = 4'h5;
    localparam logic [3:0] ALU_SRL = 4'h6;
    localparam logic [3:0] ALU_SRA = 4'h7;
    localparam logic [3:0] ALU_EQ  = 4'h8;
    localparam logic [3:0] ALU_NE  = 4'h9;
    localparam logic [3:0] ALU_LT  = 4'hA;
    localparam logic [3:0] ALU_GE  = 4'hB;
    localparam logic [3:0] ALU_LTU = 4'hC;
    localparam logic [3:0] ALU_GEU = 4'hD;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic       B_RS2  = 1'b0;
    localparam logic       B_IMM  = 1'b1;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec_t;

    // Shared funct3 map of the register and immediate ALU groups; alt picks sub/sra.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_LT;
            3'b011:  op = ALU_LTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t decode(input logic [31:0] i);
        dec_t        d;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        bad;
        logic        is_shift;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;

        opc      = i[6:0];
        f3       = i[14:12];
        f7       = i[31:25];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        imm_i    = {{20{i[31]}}, i[31:20]};
        imm_s    = {{20{i[31]}}, i[31:25], i[11:7]};
        imm_b    = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_u    = {i[31:12], 12'h000};
        imm_j    = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};

        d.alu_op    = ALU_ADD;
        d.a_sel     = A_RS1;
        d.b_sel     = B_IMM;
        d.imm       = imm_i;
        d.is_branch = 1'b0;
        d.is_jump   = 1'b0;
        d.illegal   = 1'b0;
        bad         = 1'b0;

        case (opc)
            OPC_OP: begin
                d.b_sel  = B_RS2;
                d.alu_op = f3_to_alu(f3, f7 == F7_ALT);
                bad = !((f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_OPIMM: begin
                // Only the shifts reuse funct7; for everything else those bits are immediate.
                d.alu_op = f3_to_alu(f3, (f3 == 3'b101) && (f7 == F7_ALT));
                bad = is_shift && !((f7 == F7_ZERO) || ((f3 == 3'b101) && (f7 == F7_ALT)));
            end
            OPC_LOAD: begin
                d.imm = imm_i;
            end
            OPC_STORE: begin
                d.imm = imm_s;
            end
            OPC_BRANCH: begin
                d.b_sel     = B_RS2;
                d.imm       = imm_b;
                d.is_branch = 1'b1;
                case (f3)
                    3'b000:  d.alu_op = ALU_EQ;
                    3'b001:  d.alu_op = ALU_NE;
                    3'b100:  d.alu_op = ALU_LT;
                    3'b101:  d.alu_op = ALU_GE;
                    3'b110:  d.alu_op = ALU_LTU;
                    3'b111:  d.alu_op = ALU_GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d.a_sel = A_ZERO;
                d.imm   = imm_u;
            end
            OPC_AUIPC: begin
                d.a_sel = A_PC;
                d.imm   = imm_u;
            end
            OPC_JAL: begin
                d.a_sel   = A_PC;
                d.imm     = imm_j;
                d.is_jump = 1'b1;
            end
            OPC_JALR: begin
                d.is_jump = 1'b1;
                bad       = (f3 != 3'b000);
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            d.alu_op    = ALU_ADD;
            d.a_sel     = A_RS1;
            d.b_sel     = B_RS2;
            d.is_branch = 1'b0;
            d.is_jump   = 1'b0;
            d.illegal   = 1'b1;
`else
            d.alu_op    = ALU_ADD;
            d.a_sel     = A_RS1;
            d.b_sel     = B_IMM;
            d.is_branch = 1'b0;
            d.is_jump   = 1'b0;
            d.illegal   = 1'b0;
`endif
        end
        return d;
    endfunction

    dec_t in_dec;
    dec_t nop_dec;
    dec_t out_q;
    dec_t out_d;
    logic out_valid_q;
    logic out_valid_d;
    logic accept;

    assign in_dec   = decode(inst);
    assign nop_dec  = decode(NOP_INST);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            // A concurrent handshake still completes upstream; its payload is simply dropped.
            out_d       = nop_dec;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = in_dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= nop_dec;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = out_q.alu_op;
    assign a_sel     = out_q.a_sel;
    assign b_sel     = out_q.b_sel;
    assign imm       = out_q.imm;
    assign is_branch = out_q.is_branch;
    assign is_jump   = out_q.is_jump;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Scoreboard bench for alu_ctrl_decode: directed test-plan vectors, stall/flush/reset, random traffic.
module tb_alu_ctrl_decode;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;

    alu_ctrl_decode dut (
        .clk(clk), .rst(rst), .inst(inst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .is_branch(is_branch),
        .is_jump(is_jump), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic        br;
        logic        jp;
        logic        ill;
        bit          imm_chk;
        logic [31:0] word;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h67, 7'h73, 7'h0F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        bit   ok;
        ok        = 1'b1;
        e.word    = w;
        e.op      = 4'h0;
        e.a       = 2'd0;
        e.b       = 1'b1;
        e.br      = 1'b0;
        e.jp      = 1'b0;
        e.ill     = 1'b0;
        e.imm_chk = 1'b1;
        e.imm     = {{20{w[31]}}, w[31:20]};
        case (w[6:0])
            7'h33: begin
                e.b = 1'b0;
                e.imm_chk = 1'b0;
                case ({w[31:25], w[14:12]})
                    {7'h00, 3'd0}: e.op = 4'h0;
                    {7'h20, 3'd0}: e.op = 4'h1;
                    {7'h00, 3'd1}: e.op = 4'h5;
                    {7'h00, 3'd2}: e.op = 4'hA;
                    {7'h00, 3'd3}: e.op = 4'hC;
                    {7'h00, 3'd4}: e.op = 4'h4;
                    {7'h00, 3'd5}: e.op = 4'h6;
                    {7'h20, 3'd5}: e.op = 4'h7;
                    {7'h00, 3'd6}: e.op = 4'h3;
                    {7'h00, 3'd7}: e.op = 4'h2;
                    default:       ok = 1'b0;
                endcase
            end
            7'h13: begin
                case (w[14:12])
                    3'd0: e.op = 4'h0;
                    3'd2: e.op = 4'hA;
                    3'd3: e.op = 4'hC;
                    3'd4: e.op = 4'h4;
                    3'd6: e.op = 4'h3;
                    3'd7: e.op = 4'h2;
                    3'd1: if (w[31:25] == 7'h00) e.op = 4'h5; else ok = 1'b0;
                    default: begin
                        if (w[31:25] == 7'h00)      e.op = 4'h6;
                        else if (w[31:25] == 7'h20) e.op = 4'h7;
                        else                        ok = 1'b0;
                    end
                endcase
            end
            7'h03: ;
            7'h23: e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63: begin
                e.b   = 1'b0;
                e.br  = 1'b1;
                e.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                case (w[14:12])
                    3'd0: e.op = 4'h8;
                    3'd1: e.op = 4'h9;
                    3'd4: e.op = 4'hA;
                    3'd5: e.op = 4'hB;
                    3'd6: e.op = 4'hC;
                    3'd7: e.op = 4'hD;
                    default: ok = 1'b0;
                endcase
            end
            7'h37: begin e.a = 2'd2; e.imm = {w[31:12], 12'h000}; end
            7'h17: begin e.a = 2'd1; e.imm = {w[31:12], 12'h000}; end
            7'h6F: begin
                e.a   = 2'd1;
                e.jp  = 1'b1;
                e.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'h67: begin
                e.jp = 1'b1;
                if (w[14:12] != 3'd0) ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.imm_chk = 1'b0;
            e.op = 4'h0;
            e.a  = 2'd0;
            e.br = 1'b0;
            e.jp = 1'b0;
            e.b  = TRAP ? 1'b0 : 1'b1;
            e.ill = TRAP;
        end
        return e;
    endfunction

    bit          stall_prev = 1'b0;
    logic [3:0]  s_op;
    logic [1:0]  s_a;
    logic        s_b;
    logic [31:0] s_imm;
    logic        s_br;
    logic        s_jp;
    logic        s_ill;

    // One clock of traffic: check held outputs at negedge, update the scoreboard, cross the edge.
    task automatic tick();
        exp_t e;
        logic fl;
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_alu_op", alu_op, s_op);
            chk("stall_a_sel", a_sel, s_a);
            chk("stall_b_sel", b_sel, s_b);
            chk("stall_imm", imm, s_imm);
            chk("stall_flags", {is_branch, is_jump, illegal}, {s_br, s_jp, s_ill});
        end
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1'b1, 1'b0);
            end else begin
                e = q.pop_front();
                $display("consume %h: op=%h a=%0d b=%0d imm=%h br=%0d jp=%0d ill=%0d",
                         e.word, alu_op, a_sel, b_sel, imm, is_branch, is_jump, illegal);
                chk("alu_op", alu_op, e.op);
                chk("a_sel", a_sel, e.a);
                chk("b_sel", b_sel, e.b);
                chk("is_branch", is_branch, e.br);
                chk("is_jump", is_jump, e.jp);
                chk("illegal", illegal, e.ill);
                if (e.imm_chk) chk("imm", imm, e.imm);
            end
        end else if (flush && out_valid && q.size() != 0) begin
            void'(q.pop_front());
        end
        if (in_valid && in_ready && !flush) q.push_back(model(inst));
        stall_prev = out_valid && !out_ready && !flush;
        s_op = alu_op; s_a = a_sel; s_b = b_sel; s_imm = imm;
        s_br = is_branch; s_jp = is_jump; s_ill = illegal;
        fl = flush;
        @(posedge clk);
        #1;
        chk("occupancy", out_valid, q.size() != 0);
        if (fl) chk("flush_valid", out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        int          r;
        rst = 1'b1; inst = 32'h0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_op", alu_op, 4'h0);
        chk("rst_a_sel", a_sel, 2'd0);
        chk("rst_b_sel", b_sel, 1'b1);
        chk("rst_imm", imm, 32'h0);
        chk("rst_flags", {is_branch, is_jump, illegal}, 3'b000);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed test-plan vectors, back to back with out_ready high.
        out_ready = 1'b1; in_valid = 1'b1;
        inst = 32'h402081B3; tick();
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_alu_op", alu_op, 4'h1);
        chk("sub_sels", {a_sel, b_sel}, {2'd0, 1'b0});
        inst = 32'hFFF00093; tick();
        chk("addi_alu_op", alu_op, 4'h0);
        chk("addi_imm", imm, 32'hFFFFFFFF);
        chk("addi_b_sel", b_sel, 1'b1);
        inst = 32'h4032D293; tick();
        chk("srai_alu_op", alu_op, 4'h7);
        chk("srai_shamt", imm[4:0], 5'd3);
        inst = 32'h0020E463; tick();
        chk("bltu_alu_op", alu_op, 4'hC);
        chk("bltu_branch", is_branch, 1'b1);
        chk("bltu_imm", imm, 32'd8);
        chk("bltu_b_sel", b_sel, 1'b0);
        inst = 32'hFFFFFFFF; tick();
        chk("ill_flag", illegal, TRAP);
        chk("ill_alu_op", alu_op, 4'h0);
        in_valid = 1'b0; tick(); tick();

        // Stall: one entry held for three cycles while the next instruction waits.
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h00500113; tick();
        inst = 32'h002081B3;
        repeat (3) begin
            tick();
            chk("stall_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1; tick();
        chk("release_next_valid", out_valid, 1'b1);
        chk("release_next_op", {alu_op, b_sel}, {4'h0, 1'b0});
        in_valid = 1'b0; tick(); tick();

        // Flush with a concurrent accept, then flush of a held entry.
        in_valid = 1'b1; inst = 32'h00000013; flush = 1'b1; tick();
        flush = 1'b0; out_ready = 1'b0; inst = 32'h00C000EF; tick();
        flush = 1'b1; inst = 32'h00000013; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0; in_valid = 1'b1; inst = 32'h402081B3; tick();
        in_valid = 1'b0; tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_alu_op", alu_op, 4'h0);
        chk("async_rst_b_sel", b_sel, 1'b1);
        q.delete();
        stall_prev = 1'b0;
        #1 rst = 1'b0;
        out_ready = 1'b1; tick();

        // Random traffic over mostly-legal opcodes.
        for (int n = 0; n < 400; n++) begin
            w = $urandom();
            r = $urandom_range(0, 11);
            if (r < 11) w[6:0] = opc_tab[r];
            r = $urandom_range(0, 3);
            if (r == 0) w[31:25] = 7'h00;
            else if (r == 1) w[31:25] = 7'h20;
            inst      = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end

        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 5 && q.size() != 0; n++) tick();
        chk("drain_empty", q.size(), 0);
        chk("drain_valid", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
